// File: rtl/ahb_verilog_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_verilog_sram_slave
// Purpose  : AHB-Lite SRAM slave, little-endian byte lanes, programmable
//            wait states and two-cycle ERROR response on illegal accesses.
// Revision : 1.0
// ============================================================================
module ahb_verilog_sram_slave #(
    parameter longint unsigned BASE_ADDRESS = 0,
    parameter int              MEM_DEPTH    = 256,
    parameter int              WAIT_STATES  = 0,
    parameter int              ADDRESSWIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDRESSWIDTH-1:0] HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic                    HREADY,
    output logic [31:0]             HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);

    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDRESSWIDTH-1:0] BASE    = ADDRESSWIDTH'(BASE_ADDRESS);
    localparam logic [ADDRESSWIDTH:0] MEM_BYTES = (ADDRESSWIDTH+1)'(MEM_DEPTH) << 2;
    localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic [3:0]              wait_cnt, wait_cnt_next;
    logic [31:0]             mem [MEM_DEPTH];

    logic                    dp_valid;
    logic                    dp_write;
    logic [IDX_W-1:0]        dp_idx;
    logic [3:0]              dp_be;

    logic [ADDRESSWIDTH-1:0] offset;
    logic                    out_of_range;
    logic                    misaligned;
    logic                    req_err;
    logic [3:0]              req_be;
    logic [IDX_W-1:0]        req_idx;
    logic                    can_accept;
    logic                    accept;
    logic                    completing;
    logic                    unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Address-phase decode; offset wraps, so addresses below BASE read as huge.
    always_comb begin
        offset       = HADDR - BASE;
        out_of_range = ({1'b0, offset} >= MEM_BYTES);
        misaligned   = 1'b0;
        req_be       = 4'b1111;
        case (HSIZE)
            3'd0: req_be = 4'b0001 << HADDR[1:0];
            3'd1: begin
                misaligned = HADDR[0];
                req_be     = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: misaligned = (HADDR[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        req_err = (HSIZE > 3'd2) | misaligned | out_of_range;
        req_idx = offset[IDX_W+1:2];
    end

    // Only IDLE and ERR2 present HREADYOUT=1, so only they can take a new phase.
    assign can_accept = (state == ST_IDLE) || (state == ST_ERR2);
    assign accept     = can_accept & HSEL & HREADY & HTRANS[1];
    assign completing = (state == ST_IDLE) & dp_valid;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        HREADYOUT     = 1'b1;
        HRESP         = 1'b0;
        case (state)
            ST_IDLE, ST_ERR2: begin
                HRESP      = (state == ST_ERR2);
                state_next = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT     = 1'b0;
                wait_cnt_next = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ST_ERR2;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Data-phase context; errored phases never set dp_valid.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= 4'b0000;
        end else if (can_accept) begin
            dp_valid <= accept & ~req_err;
            if (accept) begin
                dp_write <= HWRITE;
                dp_idx   <= req_idx;
                dp_be    <= req_be;
            end
        end
    end

    // Memory is deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (completing && dp_write) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_be[b]) begin
                    mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

    // A write commits at the end of its completing cycle, so any later read
    // completes no earlier than the next cycle and sees the new data.
    assign HRDATA = (completing && !dp_write) ? mem[dp_idx] : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_verilog_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_verilog_sram_slave
// Purpose  : Self-checking bench; two slaves (0 and 3 wait states) checked
//            against a byte-lane reference model.
// Revision : 1.0
// ============================================================================
module tb_ahb_verilog_sram_slave;

    localparam int          D0 = 256;
    localparam int          D3 = 64;
    localparam logic [31:0] B0 = 32'h0000_0000;
    localparam logic [31:0] B3 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        which = 1'b0;
    logic        hsel = 1'b0;
    logic        hwrite = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic [31:0] hwdata = 32'd0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd0;
    logic [31:0] rd0, rd3;
    logic        ro0, ro3, rs0, rs3;
    logic [31:0] rdata;
    logic        rdy, resp;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;

    logic [31:0] m0 [D0];
    logic [31:0] m3 [D3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata = which ? rd3 : rd0;
    assign rdy   = which ? ro3 : ro0;
    assign resp  = which ? rs3 : rs0;

    ahb_verilog_sram_slave #(.BASE_ADDRESS(0), .MEM_DEPTH(D0), .WAIT_STATES(0), .ADDRESSWIDTH(32)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~which), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro0),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

    ahb_verilog_sram_slave #(.BASE_ADDRESS(32'h1000), .MEM_DEPTH(D3), .WAIT_STATES(3), .ADDRESSWIDTH(32)) dut3 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & which), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(ro3),
        .HRDATA(rd3), .HREADYOUT(ro3), .HRESP(rs3));

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic w, input logic [31:0] a, input logic [2:0] s);
        logic [31:0] off;
        int unsigned depth;
        depth = w ? D3 : D0;
        off   = a - (w ? B3 : B0);
        if (s > 3'd2) return 1'b1;
        if ((a % (32'd1 << s)) != 32'd0) return 1'b1;
        return (off >= depth * 4);
    endfunction

    function automatic logic [31:0] mread(input logic w, input logic [31:0] a);
        int idx;
        idx = int'((a - (w ? B3 : B0)) >> 2);
        return w ? m3[idx] : m0[idx];
    endfunction

    task automatic mwrite(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        logic [31:0] word;
        int idx, lane;
        idx  = int'((a - (w ? B3 : B0)) >> 2);
        word = w ? m3[idx] : m0[idx];
        for (int i = 0; i < (1 << s); i++) begin
            lane = int'(a % 4) + i;
            word[lane*8 +: 8] = d[lane*8 +: 8];
        end
        if (w) m3[idx] = word;
        else   m0[idx] = word;
    endtask

    // ---------------- bus driver ----------------
    // Entered and left at posedge+1; returns in the completing cycle so the
    // next call's address phase overlaps it.
    task automatic xfer(input logic w, input logic [1:0] tr, input logic wr, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d,
                        output logic [31:0] rd_o, output logic rf, output logic rl, output int waits);
        which = w; hsel = 1'b1; htrans = tr; hwrite = wr; haddr = a; hsize = s;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = d;
        rf = resp;
        waits = 0;
        while (rdy !== 1'b1 && waits < 40) begin
            waits++;
            @(posedge clk); #1;
        end
        if (waits >= 40) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_timeout addr=%h ready stuck low after %0d cycles, required high", a, waits);
        end
        rl   = resp;
        rd_o = rdata;
    endtask

    task automatic idle_cycles(input int n);
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        n_cmp++;
        if ({ro0, rs0, rd0, ro3, rs3, rd3} !== {1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs got rdy0=%b resp0=%b rd0=%h rdy3=%b resp3=%b rd3=%h required 1 0 0 1 0 0",
                     ro0, rs0, rd0, ro3, rs3, rd3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        logic [31:0] rd, d;
        logic rf, rl;
        int waits;
        for (int i = 0; i < D0 + D3; i++) begin
            logic w;
            logic [31:0] a;
            w = (i >= D0);
            a = w ? B3 + 32'((i - D0) * 4) : B0 + 32'(i * 4);
            d = $urandom;
            xfer(w, 2'b10, 1'b1, a, 3'd2, d, rd, rf, rl, waits);
            n_cmp++;
            if (waits !== (w ? 3 : 0) || rl !== 1'b0 || rd !== 32'd0) begin
                n_bad++;
                $display("FAIL init_write addr=%h got waits=%0d resp=%b rd=%h required waits=%0d resp=0 rd=0",
                         a, waits, rl, rd, w ? 3 : 0);
            end
            mwrite(w, a, 3'd2, d);
        end
    endtask

    task automatic test_word_rw();
        logic [31:0] rd;
        logic rf, rl;
        int waits;
        xfer(1'b0, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, rf, rl, waits);
        n_cmp++;
        if (waits !== 0 || rl !== 1'b0 || rd !== 32'd0) begin
            n_bad++;
            $display("FAIL word_write got waits=%0d resp=%b rd=%h required 0 0 0", waits, rl, rd);
        end
        xfer(1'b0, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, rd, rf, rl, waits);
        n_cmp++;
        if (waits !== 0 || rl !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL word_read got waits=%0d resp=%b rd=%h required 0 0 deadbeef", waits, rl, rd);
        end
        mwrite(1'b0, 32'h10, 3'd2, 32'hDEADBEEF);
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic rf, rl;
        int waits;
        xfer(1'b0, 2'b10, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, rf, rl, waits);
        xfer(1'b0, 2'b10, 1'b1, 32'h13, 3'd0, 32'h55000000, rd, rf, rl, waits);
        xfer(1'b0, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, rd, rf, rl, waits);
        n_cmp++;
        if (rd !== 32'h55223344 || rl !== 1'b0) begin
            n_bad++;
            $display("FAIL byte_write got rd=%h resp=%b required 55223344 0", rd, rl);
        end
        xfer(1'b0, 2'b10, 1'b1, 32'h12, 3'd1, 32'hAAAA0000, rd, rf, rl, waits);
        xfer(1'b0, 2'b10, 1'b0, 32'h10, 3'd2, 32'd0, rd, rf, rl, waits);
        n_cmp++;
        if (rd !== 32'hAAAA3344 || rl !== 1'b0) begin
            n_bad++;
            $display("FAIL half_write got rd=%h resp=%b required aaaa3344 0", rd, rl);
        end
        m0[4] = 32'hAAAA3344;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd;
        logic rf, rl;
        int waits;
        xfer(1'b1, 2'b10, 1'b0, B3 + 32'h8, 3'd2, 32'd0, rd, rf, rl, waits);
        n_cmp++;
        if (waits !== 3 || rf !== 1'b0 || rl !== 1'b0 || rd !== m3[2]) begin
            n_bad++;
            $display("FAIL wait_read got waits=%0d resp=%b/%b rd=%h required 3 0/0 %h", waits, rf, rl, rd, m3[2]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, exp_rd;
        logic [31:0] addrs [5];
        logic        ws [5];
        logic [2:0]  ss [5];
        logic rf, rl;
        int waits;
        addrs = '{B0 + D0*4, 32'h2, B3 + D3*4, B3 - 32'd4, B3 + 32'h20};
        ws    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ss    = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
        for (int i = 0; i < 5; i++) begin
            xfer(ws[i], 2'b10, 1'b1, addrs[i], ss[i], 32'hBADBAD00 + 32'(i), rd, rf, rl, waits);
            n_cmp++;
            if (waits !== 1 || rf !== 1'b1 || rl !== 1'b1 || rd !== 32'd0) begin
                n_bad++;
                $display("FAIL error_resp case=%0d got waits=%0d resp=%b/%b rd=%h required 1 1/1 0",
                         i, waits, rf, rl, rd);
            end
        end
        // Errored writes targeted words 0x0 and 0x1020; both must be intact.
        xfer(1'b0, 2'b10, 1'b0, 32'h0, 3'd2, 32'd0, rd, rf, rl, waits);
        exp_rd = m0[0];
        n_cmp++;
        if (rd !== exp_rd || rl !== 1'b0) begin
            n_bad++;
            $display("FAIL error_nowrite0 got rd=%h required %h", rd, exp_rd);
        end
        xfer(1'b1, 2'b10, 1'b0, B3 + 32'h20, 3'd2, 32'd0, rd, rf, rl, waits);
        exp_rd = m3[8];
        n_cmp++;
        if (rd !== exp_rd || rl !== 1'b0) begin
            n_bad++;
            $display("FAIL error_nowrite3 got rd=%h required %h", rd, exp_rd);
        end
        xfer(1'b0, 2'b10, 1'b0, B0 + D0*4 - 4, 3'd2, 32'd0, rd, rf, rl, waits);
        exp_rd = m0[D0-1];
        n_cmp++;
        if (rd !== exp_rd || rl !== 1'b0 || waits !== 0) begin
            n_bad++;
            $display("FAIL last_word got rd=%h resp=%b waits=%0d required %h 0 0", rd, rl, waits, exp_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic [31:0] d [4];
        logic rf, rl;
        int waits, t0, total;
        total = 0;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            xfer(1'b0, (i == 0) ? 2'b10 : 2'b11, 1'b1, 32'h80 + 32'(i*4), 3'd2, d[i], rd, rf, rl, waits);
            total += waits;
            mwrite(1'b0, 32'h80 + 32'(i*4), 3'd2, d[i]);
        end
        n_cmp++;
        if (cyc - t0 !== 4 || total !== 0) begin
            n_bad++;
            $display("FAIL burst_timing got cycles=%0d waits=%0d required 4 0", cyc - t0, total);
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, (i == 0) ? 2'b10 : 2'b11, 1'b0, 32'h80 + 32'(i*4), 3'd2, 32'd0, rd, rf, rl, waits);
            n_cmp++;
            if (rd !== d[i] || rl !== 1'b0 || waits !== 0) begin
                n_bad++;
                $display("FAIL burst_read beat=%0d got rd=%h required %h", i, rd, d[i]);
            end
        end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd, exp_rd;
        logic [1:0]  trs [4];
        logic        sls [4];
        logic rf, rl;
        int waits;
        trs = '{2'b00, 2'b01, 2'b10, 2'b11};
        sls = '{1'b1, 1'b1, 1'b0, 1'b0};
        which = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hsel = sls[i]; htrans = trs[i]; hwrite = 1'b1; haddr = 32'h40; hsize = 3'd2;
            hwdata = $urandom;
            @(posedge clk); #1;
            n_cmp++;
            if ({ro0, rs0, rd0} !== {1'b1, 1'b0, 32'd0}) begin
                n_bad++;
                $display("FAIL non_transfer case=%0d got rdy=%b resp=%b rd=%h required 1 0 0", i, ro0, rs0, rd0);
            end
        end
        idle_cycles(1);
        xfer(1'b0, 2'b10, 1'b0, 32'h40, 3'd2, 32'd0, rd, rf, rl, waits);
        exp_rd = m0[16];
        n_cmp++;
        if (rd !== exp_rd) begin
            n_bad++;
            $display("FAIL non_transfer_nowrite got rd=%h required %h", rd, exp_rd);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd, exp_rd;
        logic rf, rl;
        int waits;
        idle_cycles(1);
        which = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = B3 + 32'h30; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; hwdata = 32'hCAFEF00D;
        n_cmp++;
        if (ro3 !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_entered got rdy=%b required 0", ro3);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ro3, rs3, rd3} !== {1'b1, 1'b0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_abort got rdy=%b resp=%b rd=%h required 1 0 0", ro3, rs3, rd3);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(1'b1, 2'b10, 1'b0, B3 + 32'h30, 3'd2, 32'd0, rd, rf, rl, waits);
        exp_rd = m3[12];
        n_cmp++;
        if (rd !== exp_rd || waits !== 3 || rl !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_nowrite got rd=%h waits=%0d required %h 3", rd, waits, exp_rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d, base, erd;
        logic [2:0]  s;
        logic [1:0]  tr;
        logic        w, wr, e, rf, rl;
        int          waits, ew, k;
        int unsigned depth;
        for (int n = 0; n < 300; n++) begin
            w     = 1'($urandom_range(0, 1));
            base  = w ? B3 : B0;
            depth = w ? D3 : D0;
            k     = int'($urandom_range(0, 9));
            if (k == 0)      a = base + depth*4 + $urandom_range(0, 15);
            else if (k == 1) a = base - $urandom_range(1, 16);
            else             a = base + $urandom_range(0, depth*4 - 1);
            s = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0 && s < 3'd3) a = a & ~((32'd1 << s) - 32'd1);
            wr = 1'($urandom_range(0, 1));
            tr = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
            d  = $urandom;
            e   = exp_err(w, a, s);
            ew  = e ? 1 : (w ? 3 : 0);
            erd = (e || wr) ? 32'd0 : mread(w, a);
            xfer(w, tr, wr, a, s, d, rd, rf, rl, waits);
            n_cmp++;
            if (waits !== ew || rf !== e || rl !== e) begin
                n_bad++;
                $display("FAIL rand_resp n=%0d addr=%h size=%0d got waits=%0d resp=%b/%b required %0d %b/%b",
                         n, a, s, waits, rf, rl, ew, e, e);
            end
            n_cmp++;
            if (rd !== erd) begin
                n_bad++;
                $display("FAIL rand_rdata n=%0d addr=%h got %h required %h", n, a, rd, erd);
            end
            if (!e && wr) mwrite(w, a, s, d);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_word_rw();
        test_byte_lanes();
        test_wait_states();
        test_errors();
        test_back_to_back();
        test_idle_busy();
        test_reset_in_wait();
        test_random();
        idle_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
